// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN input path.
// Holds the frame geometry (pixel count, packed byte count, pixel counter
// width) and the pixel transmitter FSM state type.
package bnn_pkg;

  localparam int N_PIXELS        = 784;
  localparam int BYTES_PER_FRAME = N_PIXELS / 8;
  localparam int PIX_CNT_W       = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: unpacks a frame of packed pixel bytes into a serial pixel
// stream for the pixel register loader.
//
// Ports:
//   clk        - single clock, all state on the rising edge
//   rst_n      - asynchronous active-low reset, aborts any frame
//   start      - one-cycle request to begin a frame (honoured only in IDLE)
//   byte_in    - eight packed pixels, bit0 is the lowest-index pixel
//   byte_valid - producer qualifier for byte_in
//   byte_ready - block takes byte_in on this edge when byte_valid is high
//   pix_bit    - serial pixel, LSB of byte 0 first
//   pix_valid  - pix_bit carries a real pixel this cycle
//   busy       - frame in progress
//   frame_done - one-cycle pulse the cycle after the last pixel
//   underrun   - sticky: the stream bubbled in the current or last frame
//
// All outputs are registered. Their next values are derived from the next
// state and the next datapath values, so each output shows the condition of
// the state it sits in.
module pixel_stream_tx #(
  parameter int N_PIXELS        = bnn_pkg::N_PIXELS,
  parameter int BYTES_PER_FRAME = bnn_pkg::BYTES_PER_FRAME
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       pix_bit,
  output logic       pix_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  import bnn_pkg::*;

  localparam int BCNT_W = $clog2(BYTES_PER_FRAME + 1);
  localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(N_PIXELS - 1);
  localparam logic [BCNT_W-1:0]    MAX_BYTES = BCNT_W'(BYTES_PER_FRAME);
  localparam logic [BCNT_W-1:0]    BCNT_ONE  = BCNT_W'(1);

  tx_state_e state_r;
  tx_state_e state_s;

  logic [7:0]           hold_r,      hold_s;
  logic                 hold_full_r, hold_full_s;
  logic [7:0]           shift_r,     shift_s;
  logic [3:0]           bits_r,      bits_s;
  logic [PIX_CNT_W-1:0] pix_cnt_r,   pix_cnt_s;
  logic [BCNT_W-1:0]    byte_cnt_r,  byte_cnt_s;
  logic                 last_out_r,  last_out_s;

  logic byte_ready_r, byte_ready_s;
  logic pix_bit_r,    pix_bit_s;
  logic pix_valid_r,  pix_valid_s;
  logic busy_r,       busy_s;
  logic frame_done_r, frame_done_s;
  logic underrun_r,   underrun_s;

  logic start_s;
  logic accept_s;
  logic present_s;
  logic load_s;
  logic bubble_s;

  // byte_ready_r already equals the ready condition of the current registers
  assign start_s   = (state_r == ST_IDLE) && start;
  assign accept_s  = (state_r == ST_SHIFT) && byte_valid && byte_ready_r;
  assign present_s = (state_r == ST_SHIFT) && (bits_r != 4'd0);
  // refill when empty or when the last bit leaves on this edge, so the next
  // byte follows without a gap
  assign load_s    = (state_r == ST_SHIFT) && hold_full_r &&
                     ((bits_r == 4'd0) || (bits_r == 4'd1));
  // a bubble only counts once the frame's first byte has arrived
  assign bubble_s  = (state_r == ST_SHIFT) && (bits_r == 4'd0) && !hold_full_r &&
                     (byte_cnt_r != {BCNT_W{1'b0}}) && !last_out_r;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // last_out_r marks that pixel N_PIXELS-1 is on the output now
        if (last_out_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Next datapath and output values
  always_comb begin
    hold_s      = hold_r;
    hold_full_s = hold_full_r;
    shift_s     = shift_r;
    bits_s      = bits_r;
    pix_cnt_s   = pix_cnt_r;
    byte_cnt_s  = byte_cnt_r;
    last_out_s  = last_out_r;
    underrun_s  = underrun_r;
    pix_bit_s   = 1'b0;
    pix_valid_s = 1'b0;

    if (start_s) begin
      hold_s      = 8'd0;
      hold_full_s = 1'b0;
      shift_s     = 8'd0;
      bits_s      = 4'd0;
      pix_cnt_s   = {PIX_CNT_W{1'b0}};
      byte_cnt_s  = {BCNT_W{1'b0}};
      last_out_s  = 1'b0;
      underrun_s  = 1'b0;
    end else if (state_r == ST_SHIFT) begin
      if (present_s) begin
        pix_bit_s   = shift_r[0];
        pix_valid_s = 1'b1;
        shift_s     = {1'b0, shift_r[7:1]};
        bits_s      = bits_r - 4'd1;
        // the counter saturates at the last index; last_out ends the frame
        if (pix_cnt_r == LAST_PIX) begin
          last_out_s = 1'b1;
        end else begin
          pix_cnt_s = pix_cnt_r + 10'd1;
        end
      end else begin
        pix_bit_s   = 1'b0;
        pix_valid_s = 1'b0;
      end

      if (load_s) begin
        shift_s     = hold_r;
        bits_s      = 4'd8;
        hold_full_s = 1'b0;
      end else begin
        hold_full_s = hold_full_r;
      end

      // a byte taken on the same edge as a load leaves hold full again
      if (accept_s) begin
        hold_s      = byte_in;
        hold_full_s = 1'b1;
        byte_cnt_s  = byte_cnt_r + BCNT_ONE;
      end else begin
        hold_s = hold_r;
      end

      if (bubble_s) begin
        underrun_s = 1'b1;
      end else begin
        underrun_s = underrun_r;
      end
    end else begin
      pix_bit_s   = 1'b0;
      pix_valid_s = 1'b0;
    end

    byte_ready_s = (state_s == ST_SHIFT) && !hold_full_s && (byte_cnt_s < MAX_BYTES);
    busy_s       = (state_s == ST_SHIFT);
    frame_done_s = (state_s == ST_DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r       <= 8'd0;
      hold_full_r  <= 1'b0;
      shift_r      <= 8'd0;
      bits_r       <= 4'd0;
      pix_cnt_r    <= {PIX_CNT_W{1'b0}};
      byte_cnt_r   <= {BCNT_W{1'b0}};
      last_out_r   <= 1'b0;
      byte_ready_r <= 1'b0;
      pix_bit_r    <= 1'b0;
      pix_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      hold_r       <= hold_s;
      hold_full_r  <= hold_full_s;
      shift_r      <= shift_s;
      bits_r       <= bits_s;
      pix_cnt_r    <= pix_cnt_s;
      byte_cnt_r   <= byte_cnt_s;
      last_out_r   <= last_out_s;
      byte_ready_r <= byte_ready_s;
      pix_bit_r    <= pix_bit_s;
      pix_valid_r  <= pix_valid_s;
      busy_r       <= busy_s;
      frame_done_r <= frame_done_s;
      underrun_r   <= underrun_s;
    end
  end

  assign byte_ready = byte_ready_r;
  assign pix_bit    = pix_bit_r;
  assign pix_valid  = pix_valid_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign underrun   = underrun_r;

endmodule

// File: doc/pixel_stream_tx.md
PIXEL_STREAM_TX -- requirements
Module: pixel_stream_tx

Interface
REQ-001 SHALL have parameter N_PIXELS, default 784: pixels per frame.
REQ-002 SHALL have parameter BYTES_PER_FRAME, default N_PIXELS/8 = 98: packed bytes per frame.
REQ-003 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have start  input  1  single-cycle request to begin one frame.
REQ-006 SHALL have byte_in  input  8  packed pixels; bit0 = lowest-index pixel.
REQ-007 SHALL have byte_valid  input  1  producer byte qualifier.
REQ-008 SHALL have byte_ready  output  1  block accepts byte_in this cycle.
REQ-009 SHALL have pix_bit  output  1  serial pixel, the d_in_p source for the pixel register loader.
REQ-010 SHALL have pix_valid  output  1  pix_bit is a real pixel this cycle.
REQ-011 SHALL have busy  output  1  frame in progress.
REQ-012 SHALL have frame_done  output  1  one-cycle pulse after the last pixel.
REQ-013 SHALL have underrun  output  1  sticky: a bubble occurred in the current or last frame.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL, in IDLE with start=1, enter SHIFT; clear pixel counter, byte counter, holding register and underrun; set busy.
REQ-016 SHALL ignore start outside IDLE.
REQ-017 SHALL contain an 8-bit holding register with full flag and an 8-bit shift register with a 4-bit remaining-bit count.
REQ-018 SHALL drive byte_ready = (state==SHIFT) && !hold_full && (bytes_accepted < BYTES_PER_FRAME); byte_ready SHALL be 0 in IDLE and DONE.
REQ-019 SHALL accept a byte on any edge where byte_valid && byte_ready: byte_in into hold, hold_full=1, byte counter +1.
REQ-020 SHALL, when the shift register is empty or presenting its last bit and hold_full=1, load hold into the shift register on that edge and clear hold_full; a simultaneous accept and load SHALL leave hold_full=1 with the new byte.
REQ-021 SHALL, while the shift register holds bits, drive pix_bit = shift[0], pix_valid=1, shift right and advance the pixel counter by 1 per cycle, LSB first, byte 0 first.
REQ-022 SHALL present the first pixel with pix_valid=1 exactly 2 cycles after the edge accepting byte 0.
REQ-023 SHALL keep pix_valid contiguous across byte boundaries when the next byte is in hold by the cycle the current byte's bit7 is presented.
REQ-024 SHALL, in SHIFT with the shift register empty, hold empty and pixels remaining, drive pix_valid=0, pix_bit=0 and hold the counters; underrun SHALL set to 1 and remain set.
REQ-025 SHALL drive pix_bit=0 whenever pix_valid=0.
REQ-026 SHALL use a 10-bit pixel counter 0..N_PIXELS-1 with no wrap; after pixel N_PIXELS-1 it SHALL enter DONE.
REQ-027 SHALL, in DONE, assert frame_done for exactly one cycle with busy=0, then return to IDLE.
REQ-028 SHALL never accept more than BYTES_PER_FRAME bytes per frame; a byte_valid held after the last byte SHALL remain unaccepted.

Reset
REQ-029 SHALL, on rst_n=0 at any time including mid-frame, immediately abort the frame: state=IDLE, counters=0, hold_full=0, shift register and count=0.
REQ-030 SHALL hold byte_ready=0, pix_bit=0, pix_valid=0, busy=0, frame_done=0 and underrun=0 during reset.

Structure
REQ-031 SHALL take N_PIXELS, BYTES_PER_FRAME and the FSM state typedef from the shared bnn_pkg package.
REQ-032 SHALL be a single module; no sub-module.

Verification
REQ-033 Bench SHALL apply start, then 98 bytes of 0xA5 with byte_valid always 1 -> pix_bit repeats 1,0,1,0,0,1,0,1; pix_valid runs 784 contiguous cycles; frame_done pulses 1 cycle later; underrun=0.
REQ-034 Bench SHALL apply byte 0 = 0x01, byte 1 delivered 12 cycles late -> pix_valid=0 bubble between pixels 7 and 8; underrun=1; 784 valid pixels total.
REQ-035 Bench SHALL assert start while busy and hold byte_valid=1 after byte 98 -> no restart, no 99th accept, byte_ready=0.
REQ-036 Bench SHALL deassert rst_n at pixel 400 -> all outputs 0 next; a new start yields a clean full frame with underrun=0.
REQ-037 Bench SHALL hold start in IDLE with byte_valid=1 before start -> byte_ready=0 and no accept until SHIFT is entered.
